l2_arbiter: RTL and testbench
=============================

L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 32, byte address width.
- LINE_W, 256, cache line width in bits.

REQ-002 Ports SHALL be (clock and reset first):
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- icache_read  in  1  I-cache line-fill request.
- icache_address  in  ADDR_W  I-cache line address.
- icache_rdata  out  LINE_W  fill data to I-cache.
- icache_resp  out  1  I-cache request complete.
- dcache_read  in  1  D-cache line-fill request.
- dcache_write  in  1  D-cache writeback request.
- dcache_address  in  ADDR_W  D-cache line address.
- dcache_wdata  in  LINE_W  writeback data.
- dcache_rdata  out  LINE_W  fill data to D-cache.
- dcache_resp  out  1  D-cache request complete.
- l2_read  out  1  read request to L2 cache.
- l2_write  out  1  write request to L2 cache.
- l2_address  out  ADDR_W  L2 address.
- l2_wdata  out  LINE_W  L2 write data.
- l2_rdata  in  LINE_W  L2 read data.
- l2_resp  in  1  L2 request complete.

Function
REQ-003 The block SHALL share the single L2 cache port between I-cache and D-cache with at most one outstanding L2 transaction.
REQ-004 FSM states SHALL be IDLE, SERVE_I, SERVE_D.
REQ-005 IDLE transitions:
- only I pending -> SERVE_I.
- only D pending (dcache_read|dcache_write) -> SERVE_D.
- both pending -> requester not granted last (round-robin).
- none pending -> stay IDLE.
REQ-006 On the IDLE->SERVE_x edge the block SHALL latch address, op (read/write) and, for D writes, wdata into internal registers; l2_address/l2_wdata SHALL come only from these registers.
REQ-007 l2_read/l2_write SHALL be asserted combinationally from state and latched op, never in IDLE; request-to-l2 latency SHALL be exactly 1 cycle.
REQ-008 If dcache_read and dcache_write are both high at grant, the write SHALL be performed.
REQ-009 In SERVE_x, when l2_resp=1:
- x_resp SHALL be 1 in that same cycle.
- x_rdata SHALL equal l2_rdata in that same cycle.
- FSM SHALL return to IDLE on the next edge.
REQ-010 x_resp SHALL be 0 in every other cycle; the non-served requester's resp SHALL stay 0.
REQ-011 x_rdata SHALL be l2_rdata whenever the corresponding resp is 1; value otherwise don't-care.
REQ-012 Requesters SHALL hold request and address stable until resp and drop the request in the cycle after resp; the block SHALL rely on this and re-sample in IDLE (no fixed gap cycle required).
REQ-013 Requester input changes during SERVE_x SHALL NOT affect l2_address, l2_wdata or op.
REQ-014 A last_grant bit SHALL record the requester granted most recently, updated on each IDLE->SERVE_x edge.
REQ-015 l2_resp in IDLE SHALL be ignored.
REQ-016 No timeout: SERVE_x SHALL wait indefinitely for l2_resp.

Reset
REQ-017 rst_n=0 SHALL immediately, without waiting for a clock edge, force:
- state=IDLE, last_grant=I (first contention goes to D).
- latched registers=0.
- l2_read=l2_write=icache_resp=dcache_resp=0.
REQ-018 Reset mid-transaction SHALL abandon the transaction; no resp SHALL be issued for it after reset release.

Verification
REQ-019 Bench SHALL cover:
- Lone I read addr 0x0000_1000, l2_resp after 5 cycles with rdata=0xA5..A5 -> l2_read at cycle 1, l2_address=0x1000, icache_resp 1 cycle at l2_resp with icache_rdata=0xA5..A5, dcache_resp=0.
- I read and D write asserted together after reset -> D served first (l2_write=1, l2_wdata=dcache_wdata); after D resp, I served next (l2_read=1); repeat contention -> alternates.
- D asserts read+write together at addr 0x2000 -> l2_write=1, l2_read=0.
- During SERVE_D, change dcache_address 0x2000->0x3000 -> l2_address remains 0x2000 until resp.
- rst_n low 2 cycles into SERVE_I -> l2_read drops asynchronously; later l2_resp pulse yields no icache_resp.
- l2_resp pulsed while IDLE -> no resp to either requester, state stays IDLE.

Source files
------------

// File: rtl/l2_arbiter.sv
// l2_arbiter: shares one L2 cache port between the I-cache and the D-cache.
// One L2 transaction in flight at a time; contention is resolved round-robin.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no transaction; sample requests and grant one of them
// SERVE_I | I-cache fill in flight; waits for l2_resp
// SERVE_D | D-cache fill or writeback in flight; waits for l2_resp
module l2_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icache_read,
  input  logic [ADDR_W-1:0] icache_address,
  output logic [LINE_W-1:0] icache_rdata,
  output logic              icache_resp,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [ADDR_W-1:0] dcache_address,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              dcache_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            state, state_nxt;
  // last_grant: 0 = I-cache, 1 = D-cache
  logic              last_grant, last_grant_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [LINE_W-1:0] wdata_q, wdata_nxt;
  logic              write_q, write_nxt;
  logic              i_pend, d_pend;

  assign i_pend = icache_read;
  assign d_pend = dcache_read | dcache_write;

  // State, grant history and latched transaction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      addr_q     <= addr_nxt;
      wdata_q    <= wdata_nxt;
      write_q    <= write_nxt;
    end
  end

  // Grant selection, transaction latching and response routing.
  // The L2 request is decoded from the registered state only, so an
  // asynchronous reset drops it at once and requester inputs cannot
  // disturb a transaction already in flight.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    addr_nxt       = addr_q;
    wdata_nxt      = wdata_q;
    write_nxt      = write_q;
    l2_read        = 1'b0;
    l2_write       = 1'b0;
    icache_resp    = 1'b0;
    dcache_resp    = 1'b0;

    case (state)
      IDLE: begin
        // D wins when alone, or when contending and I was granted last.
        if (d_pend && (!i_pend || !last_grant)) begin
          state_nxt      = SERVE_D;
          last_grant_nxt = 1'b1;
          addr_nxt       = dcache_address;
          write_nxt      = dcache_write;
          if (dcache_write) begin
            wdata_nxt = dcache_wdata;
          end
        end else if (i_pend) begin
          state_nxt      = SERVE_I;
          last_grant_nxt = 1'b0;
          addr_nxt       = icache_address;
          write_nxt      = 1'b0;
        end
      end
      SERVE_I: begin
        l2_read     = 1'b1;
        icache_resp = l2_resp;
        if (l2_resp) begin
          state_nxt = IDLE;
        end
      end
      SERVE_D: begin
        l2_read     = !write_q;
        l2_write    = write_q;
        dcache_resp = l2_resp;
        if (l2_resp) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign l2_address   = addr_q;
  assign l2_wdata     = wdata_q;
  assign icache_rdata = l2_rdata;
  assign dcache_rdata = l2_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: directed corner sequences, a table of arbitration
// scenarios, and a randomized run against a transaction-level model.
module tb_l2_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              icache_read;
  logic [ADDR_W-1:0] icache_address;
  logic [LINE_W-1:0] icache_rdata;
  logic              icache_resp;
  logic              dcache_read;
  logic              dcache_write;
  logic [ADDR_W-1:0] dcache_address;
  logic [LINE_W-1:0] dcache_wdata;
  logic [LINE_W-1:0] dcache_rdata;
  logic              dcache_resp;
  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_address;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata;
  logic              l2_resp;

  int checks = 0;
  int errors = 0;

  l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          i_rd;
    bit          d_rd;
    bit          d_wr;
    logic [31:0] i_addr;
    logic [31:0] d_addr;
    logic [255:0] d_wdata;
    int          first;      // 0 none, 1 I, 2 D
    bit          first_wr;
    int          second;
    bit          second_wr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    icache_read = 1'b0; icache_address = '0;
    dcache_read = 1'b0; dcache_write = 1'b0; dcache_address = '0; dcache_wdata = '0;
    l2_resp = 1'b0; l2_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Entered one slot after a rising edge in an IDLE cycle with requests driven.
  task automatic serve_expect(input string tag, input int who, input bit wr,
                              input logic [31:0] addr, input logic [255:0] wdata,
                              input logic [255:0] rdata);
    next_cycle();
    @(negedge clk);
    chk({tag, " l2_read"}, l2_read, !wr);
    chk({tag, " l2_write"}, l2_write, wr);
    chk({tag, " l2_address"}, l2_address, addr);
    if (wr) chk({tag, " l2_wdata"}, l2_wdata, wdata);
    chk({tag, " early resp"}, {icache_resp, dcache_resp}, 2'b00);
    next_cycle();
    l2_resp = 1'b1;
    l2_rdata = rdata;
    @(negedge clk);
    chk({tag, " icache_resp"}, icache_resp, who == 1);
    chk({tag, " dcache_resp"}, dcache_resp, who == 2);
    if (who == 1) chk({tag, " icache_rdata"}, icache_rdata, rdata);
    else          chk({tag, " dcache_rdata"}, dcache_rdata, rdata);
    next_cycle();
    l2_resp = 1'b0;
    if (who == 1) icache_read = 1'b0;
    else begin dcache_read = 1'b0; dcache_write = 1'b0; end
  endtask

  // Transaction-level reference: who owns the port, what was captured, who went last.
  int           m_owner;
  int           m_last;
  logic [31:0]  m_addr;
  logic [255:0] m_wdata;
  bit           m_write;

  initial begin
    logic [255:0] rd_line;
    logic [255:0] a5;
    bit i_act, d_act, i_drop, d_drop;
    bit e_ir, e_dr;
    int win;

    a5 = {32{8'hA5}};
    do_reset();

    // Reset values and lone I read with 5-cycle L2 latency.
    @(negedge clk);
    chk("rst l2_read", l2_read, 1'b0);
    chk("rst l2_write", l2_write, 1'b0);
    chk("rst resps", {icache_resp, dcache_resp}, 2'b00);
    chk("rst l2_address", l2_address, 32'h0);
    next_cycle();
    icache_read = 1'b1; icache_address = 32'h0000_1000;
    @(negedge clk);
    chk("lone idle l2_read", l2_read, 1'b0);
    next_cycle();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("lone l2_read", l2_read, 1'b1);
      chk("lone l2_address", l2_address, 32'h0000_1000);
      chk("lone wait resp", icache_resp, 1'b0);
      next_cycle();
    end
    l2_resp = 1'b1; l2_rdata = a5;
    @(negedge clk);
    chk("lone icache_resp", icache_resp, 1'b1);
    chk("lone icache_rdata", icache_rdata, a5);
    chk("lone dcache_resp", dcache_resp, 1'b0);
    next_cycle();
    l2_resp = 1'b0; icache_read = 1'b0;
    @(negedge clk);
    chk("lone after l2_read", l2_read, 1'b0);
    chk("lone after resp", icache_resp, 1'b0);

    // Arbitration table, starting from a fresh reset (first contention goes to D).
    vecs[0] = '{1, 0, 1, 32'h1100, 32'h2200, {8{32'hD0D0_0001}}, 2, 1, 1, 0};
    vecs[1] = '{1, 1, 0, 32'h1140, 32'h2240, {8{32'hD0D0_0002}}, 2, 0, 1, 0};
    vecs[2] = '{0, 1, 1, 32'h0,    32'h2000, {8{32'hD0D0_0003}}, 2, 1, 0, 0};
    vecs[3] = '{1, 0, 1, 32'h1180, 32'h2280, {8{32'hD0D0_0004}}, 1, 0, 2, 1};
    vecs[4] = '{1, 0, 0, 32'h11C0, 32'h0,    {8{32'h0}},         1, 0, 0, 0};
    vecs[5] = '{0, 1, 0, 32'h0,    32'h22C0, {8{32'h0}},         2, 0, 0, 0};
    vecs[6] = '{1, 1, 0, 32'h1200, 32'h2300, {8{32'h0}},         1, 0, 2, 0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      icache_read = vecs[i].i_rd; icache_address = vecs[i].i_addr;
      dcache_read = vecs[i].d_rd; dcache_write = vecs[i].d_wr;
      dcache_address = vecs[i].d_addr; dcache_wdata = vecs[i].d_wdata;
      rd_line = {8{32'h5A5A_0000 + i}};
      serve_expect($sformatf("vec%0d first", i), vecs[i].first, vecs[i].first_wr,
                   vecs[i].first == 1 ? vecs[i].i_addr : vecs[i].d_addr,
                   vecs[i].d_wdata, rd_line);
      if (vecs[i].second != 0)
        serve_expect($sformatf("vec%0d second", i), vecs[i].second, vecs[i].second_wr,
                     vecs[i].second == 1 ? vecs[i].i_addr : vecs[i].d_addr,
                     vecs[i].d_wdata, ~rd_line);
    end
    @(negedge clk);
    chk("idle none l2_read", l2_read, 1'b0);
    chk("idle none l2_write", l2_write, 1'b0);
    next_cycle();

    // D inputs change during SERVE_D; captured address/data must hold.
    dcache_write = 1'b1; dcache_address = 32'h2000; dcache_wdata = {8{32'h1234_5678}};
    next_cycle();
    dcache_address = 32'h3000; dcache_wdata = {8{32'hFFFF_0000}}; dcache_write = 1'b0; dcache_read = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold l2_address", l2_address, 32'h2000);
      chk("hold l2_wdata", l2_wdata, {8{32'h1234_5678}});
      chk("hold l2_write", l2_write, 1'b1);
      next_cycle();
    end
    l2_resp = 1'b1; l2_rdata = a5;
    @(negedge clk);
    chk("hold dcache_resp", dcache_resp, 1'b1);
    next_cycle();
    l2_resp = 1'b0; dcache_read = 1'b0;

    // Reset two cycles into SERVE_I: abandon, no late response.
    icache_read = 1'b1; icache_address = 32'h4000;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("pre-reset l2_read", l2_read, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("async reset l2_read", l2_read, 1'b0);
    icache_read = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    l2_resp = 1'b1; l2_rdata = a5;
    @(negedge clk);
    chk("abandoned icache_resp", icache_resp, 1'b0);
    chk("abandoned l2_read", l2_read, 1'b0);
    next_cycle();
    l2_resp = 1'b0;

    // l2_resp while IDLE is ignored; a following request still works normally.
    l2_resp = 1'b1;
    @(negedge clk);
    chk("idle resp ignored", {icache_resp, dcache_resp}, 2'b00);
    next_cycle();
    l2_resp = 1'b0;
    @(negedge clk);
    chk("idle stays l2_read", l2_read, 1'b0);
    chk("idle stays l2_write", l2_write, 1'b0);
    next_cycle();
    dcache_read = 1'b1; dcache_address = 32'h5000;
    serve_expect("after idle resp", 2, 1'b0, 32'h5000, '0, a5);

    // Randomized run against the reference model.
    do_reset();
    m_owner = 0; m_last = 1; m_addr = '0; m_wdata = '0; m_write = 1'b0;
    i_act = 0; d_act = 0; i_drop = 0; d_drop = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (i_drop) begin i_act = 0; i_drop = 0; end
      else if (!i_act && $urandom_range(2) == 0) begin
        i_act = 1; icache_address = $urandom;
      end
      if (d_drop) begin d_act = 0; d_drop = 0; end
      else if (!d_act && $urandom_range(2) == 0) begin
        int op;
        op = $urandom_range(2);
        d_act = 1; dcache_address = $urandom; dcache_wdata = rand_line();
        dcache_read = (op != 1); dcache_write = (op != 0);
      end
      icache_read = i_act;
      if (!d_act) begin dcache_read = 1'b0; dcache_write = 1'b0; end
      l2_resp = ($urandom_range(3) == 0);
      l2_rdata = rand_line();
      @(negedge clk);
      e_ir = (m_owner == 1) && l2_resp;
      e_dr = (m_owner == 2) && l2_resp;
      chk("rnd l2_read", l2_read, (m_owner != 0) && !m_write);
      chk("rnd l2_write", l2_write, (m_owner != 0) && m_write);
      chk("rnd icache_resp", icache_resp, e_ir);
      chk("rnd dcache_resp", dcache_resp, e_dr);
      if (m_owner != 0) chk("rnd l2_address", l2_address, m_addr);
      if (m_owner != 0 && m_write) chk("rnd l2_wdata", l2_wdata, m_wdata);
      if (e_ir) chk("rnd icache_rdata", icache_rdata, l2_rdata);
      if (e_dr) chk("rnd dcache_rdata", dcache_rdata, l2_rdata);
      if (e_ir) i_drop = 1;
      if (e_dr) d_drop = 1;
      if (m_owner == 0) begin
        if (icache_read && (dcache_read || dcache_write)) win = (m_last == 1) ? 2 : 1;
        else if (icache_read) win = 1;
        else if (dcache_read || dcache_write) win = 2;
        else win = 0;
        if (win == 1) begin
          m_owner = 1; m_last = 1; m_addr = icache_address; m_write = 1'b0;
        end else if (win == 2) begin
          m_owner = 2; m_last = 2; m_addr = dcache_address; m_write = dcache_write;
          if (dcache_write) m_wdata = dcache_wdata;
        end
      end else if (l2_resp) begin
        m_owner = 0;
      end
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
